// File: rtl/alu_add_sub_pkg.sv
// Shared ALU package for the adder/subtractor slice.
// Holds the default datapath width, the CLA group size, and the
// encoding of the add/subtract select used by the ALU decoder.
package alu_add_sub_pkg;

  // Default operand/result width of the shared ALU datapath.
  localparam int ALU_WIDTH = 32;

  // Bits per carry-lookahead group.
  localparam int CLA_GROUP = 4;

  // Add/subtract select as seen on the 'sub' input.
  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } aluOp_e;

endpackage

// File: rtl/alu_add_sub_cla4_block.sv
// 4-bit carry-lookahead slice.
// Produces the 4-bit sum for its group plus the group generate and
// group propagate terms used by the second-level lookahead unit.
// Ports:
//   a_i[3:0], b_i[3:0] : operand bits of this group (b already inverted for subtract)
//   c_i                : carry into bit 0 of the group
//   sum_o[3:0]         : sum bits
//   gen_o              : group generates a carry regardless of c_i
//   prop_o             : group passes c_i through to its carry out
module cla4_block (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] sum_o,
  output logic       gen_o,
  output logic       prop_o
);

  logic [3:0] bitGen;
  logic [3:0] bitProp;
  logic [3:0] bitCarry;

  // Per-bit generate/propagate, then every internal carry is a flat
  // sum-of-products of those terms so no carry ripples inside the group.
  always_comb begin
    bitGen   = a_i & b_i;
    bitProp  = a_i ^ b_i;
    bitCarry[0] = c_i;
    bitCarry[1] = bitGen[0] | (bitProp[0] & c_i);
    bitCarry[2] = bitGen[1] | (bitProp[1] & bitGen[0]) |
                  (bitProp[1] & bitProp[0] & c_i);
    bitCarry[3] = bitGen[2] | (bitProp[2] & bitGen[1]) |
                  (bitProp[2] & bitProp[1] & bitGen[0]) |
                  (bitProp[2] & bitProp[1] & bitProp[0] & c_i);
    sum_o  = bitProp ^ bitCarry;
    gen_o  = bitGen[3] | (bitProp[3] & bitGen[2]) |
             (bitProp[3] & bitProp[2] & bitGen[1]) |
             (bitProp[3] & bitProp[2] & bitProp[1] & bitGen[0]);
    prop_o = &bitProp;
  end

endmodule

// File: rtl/alu_add_sub.sv
// Two's-complement adder/subtractor for the shared ALU datapath.
// Combinational path: result = a + b (sub=0) or a - b (sub=1), with carry
// out of the MSB and signed positive/negative overflow flags. Built from
// 4-bit CLA slices and a second-level lookahead across the slices.
// Registered path: snapshot of the last enabled result/overflow flags and
// sticky overflow status, all cleared asynchronously by rst.
// Ports:
//   clk, rst              : clock (rising edge), async active-high reset
//   a, b, sub             : operands and add/subtract select
//   en, clr_sticky        : capture enable, synchronous sticky clear
//   result, carry_out     : combinational sum/difference and MSB carry
//   pos_overflow, neg_overflow : combinational signed overflow flags
//   result_q, pos_ovf_q, neg_ovf_q : registered copies (loaded when en=1)
//   pos_ovf_sticky, neg_ovf_sticky : sticky overflow status
module alu_add_sub
  import alu_add_sub_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             en,
  input  logic             clr_sticky,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             pos_overflow,
  output logic             neg_overflow,
  output logic [WIDTH-1:0] result_q,
  output logic             pos_ovf_q,
  output logic             neg_ovf_q,
  output logic             pos_ovf_sticky,
  output logic             neg_ovf_sticky
);

  localparam int NG  = WIDTH / CLA_GROUP;
  localparam int MSB = WIDTH - 1;

  aluOp_e           op;
  logic [WIDTH-1:0] bEff;
  logic [NG-1:0]    groupGen;
  logic [NG-1:0]    groupProp;
  logic [NG:0]      groupCarry;

  logic [WIDTH-1:0] result_d;
  logic             pos_ovf_d;
  logic             neg_ovf_d;
  logic             pos_sticky_d;
  logic             neg_sticky_d;

  // Carry into group idx, written as the full lookahead expansion:
  // any lower group that generates and whose upper neighbours all
  // propagate, or the carry-in propagated through every lower group.
  function automatic logic lookaheadCarry(input logic [NG-1:0] gen,
                                          input logic [NG-1:0] prop,
                                          input logic          cin,
                                          input int            idx);
    logic carry;
    logic term;
    carry = 1'b0;
    for (int j = 0; j < idx; j++) begin
      term = gen[j];
      for (int k = j + 1; k < idx; k++) begin
        term = term & prop[k];
      end
      carry = carry | term;
    end
    term = cin;
    for (int k = 0; k < idx; k++) begin
      term = term & prop[k];
    end
    return carry | term;
  endfunction

  // Subtraction is a + ~b + 1, with the +1 entering as the carry-in.
  assign op   = aluOp_e'(sub);
  assign bEff = (op == OP_SUB) ? ~b : b;

  assign groupCarry[0] = sub;

  for (genvar g = 0; g < NG; g++) begin : gSlice
    cla4_block uSlice (
      .a_i    (a[CLA_GROUP*g +: CLA_GROUP]),
      .b_i    (bEff[CLA_GROUP*g +: CLA_GROUP]),
      .c_i    (groupCarry[g]),
      .sum_o  (result[CLA_GROUP*g +: CLA_GROUP]),
      .gen_o  (groupGen[g]),
      .prop_o (groupProp[g])
    );
  end

  for (genvar i = 1; i <= NG; i++) begin : gCarry
    assign groupCarry[i] = lookaheadCarry(groupGen, groupProp, sub, i);
  end

  // Overflow only when both effective operands share a sign and the
  // result sign disagrees with it.
  assign carry_out    = groupCarry[NG];
  assign pos_overflow = ~a[MSB] & ~bEff[MSB] &  result[MSB];
  assign neg_overflow =  a[MSB] &  bEff[MSB] & ~result[MSB];

  // Snapshot loads only when enabled; a new overflow setting a sticky
  // flag takes priority over a clear arriving in the same cycle.
  always_comb begin
    result_d     = result_q;
    pos_ovf_d    = pos_ovf_q;
    neg_ovf_d    = neg_ovf_q;
    pos_sticky_d = pos_ovf_sticky;
    neg_sticky_d = neg_ovf_sticky;
    if (en) begin
      result_d  = result;
      pos_ovf_d = pos_overflow;
      neg_ovf_d = neg_overflow;
    end
    if (en && pos_overflow) begin
      pos_sticky_d = 1'b1;
    end else if (clr_sticky) begin
      pos_sticky_d = 1'b0;
    end
    if (en && neg_overflow) begin
      neg_sticky_d = 1'b1;
    end else if (clr_sticky) begin
      neg_sticky_d = 1'b0;
    end
  end

  // Registered status, cleared immediately by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q       <= '0;
      pos_ovf_q      <= 1'b0;
      neg_ovf_q      <= 1'b0;
      pos_ovf_sticky <= 1'b0;
      neg_ovf_sticky <= 1'b0;
    end else begin
      result_q       <= result_d;
      pos_ovf_q      <= pos_ovf_d;
      neg_ovf_q      <= neg_ovf_d;
      pos_ovf_sticky <= pos_sticky_d;
      neg_ovf_sticky <= neg_sticky_d;
    end
  end

endmodule

// File: tb/tb_alu_add_sub.sv
// Self-checking bench for alu_add_sub: directed vector table, hand-written
// register/sticky/reset sequences, and a randomized sweep against an
// arithmetic reference model.
module tb_alu_add_sub;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          sub;
  logic          en;
  logic          clr_sticky;
  logic [W-1:0]  result;
  logic          carry_out;
  logic          pos_overflow;
  logic          neg_overflow;
  logic [W-1:0]  result_q;
  logic          pos_ovf_q;
  logic          neg_ovf_q;
  logic          pos_ovf_sticky;
  logic          neg_ovf_sticky;

  int checks = 0;
  int errors = 0;

  // Expected state of the registered outputs.
  logic [W-1:0] mResQ;
  logic         mPosQ;
  logic         mNegQ;
  logic         mPosS;
  logic         mNegS;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vsub;
    logic [W-1:0] expRes;
    logic         expCarry;
    logic         expPos;
    logic         expNeg;
  } vec_t;

  vec_t vecs[10];

  alu_add_sub #(.WIDTH(W)) dut (
    .clk            (clk),
    .rst            (rst),
    .a              (a),
    .b              (b),
    .sub            (sub),
    .en             (en),
    .clr_sticky     (clr_sticky),
    .result         (result),
    .carry_out      (carry_out),
    .pos_overflow   (pos_overflow),
    .neg_overflow   (neg_overflow),
    .result_q       (result_q),
    .pos_ovf_q      (pos_ovf_q),
    .neg_ovf_q      (neg_ovf_q),
    .pos_ovf_sticky (pos_ovf_sticky),
    .neg_ovf_sticky (neg_ovf_sticky)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [W-1:0] actual,
                             input logic [W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (a=%h b=%h sub=%b)",
               name, actual, expected, a, b, sub);
    end
  endtask

  // Reference: true signed result from 64-bit arithmetic, carry from the
  // unsigned meaning of the operation (sum >= 2^W, or no borrow: a >= b).
  task automatic refModel(input logic [W-1:0] ai, input logic [W-1:0] bi,
                          input logic si, output logic [W-1:0] r,
                          output logic c, output logic p, output logic n);
    longint sa, sb, tru;
    longint unsigned ua, ub;
    sa  = longint'($signed(ai));
    sb  = longint'($signed(bi));
    ua  = longint'(ai);
    ub  = longint'(bi);
    tru = si ? (sa - sb) : (sa + sb);
    r   = tru[W-1:0];
    p   = (tru > 64'sd2147483647);
    n   = (tru < -64'sd2147483648);
    c   = si ? (ua >= ub) : ((ua + ub) >= 64'd4294967296);
  endtask

  // Applies one operand set in a cycle: checks the combinational outputs
  // before the edge, the registered outputs just after it.
  task automatic applyStimulus(input logic [W-1:0] ai, input logic [W-1:0] bi,
                               input logic si, input logic ei, input logic ci);
    logic [W-1:0] r;
    logic c, p, n;
    @(negedge clk);
    a = ai; b = bi; sub = si; en = ei; clr_sticky = ci;
    #1;
    refModel(ai, bi, si, r, c, p, n);
    checkOutput("result", result, r);
    checkOutput("carry_out", {31'd0, carry_out}, {31'd0, c});
    checkOutput("pos_overflow", {31'd0, pos_overflow}, {31'd0, p});
    checkOutput("neg_overflow", {31'd0, neg_overflow}, {31'd0, n});
    if (ei) begin
      mResQ = r; mPosQ = p; mNegQ = n;
    end
    if (ei && p) mPosS = 1'b1;
    else if (ci) mPosS = 1'b0;
    if (ei && n) mNegS = 1'b1;
    else if (ci) mNegS = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("result_q", result_q, mResQ);
    checkOutput("pos_ovf_q", {31'd0, pos_ovf_q}, {31'd0, mPosQ});
    checkOutput("neg_ovf_q", {31'd0, neg_ovf_q}, {31'd0, mNegQ});
    checkOutput("pos_ovf_sticky", {31'd0, pos_ovf_sticky}, {31'd0, mPosS});
    checkOutput("neg_ovf_sticky", {31'd0, neg_ovf_sticky}, {31'd0, mNegS});
  endtask

  function automatic logic [W-1:0] pickOperand();
    logic [W-1:0] corners[6];
    corners[0] = 32'h0000_0000; corners[1] = 32'h0000_0001;
    corners[2] = 32'h7FFF_FFFF; corners[3] = 32'h8000_0000;
    corners[4] = 32'hFFFF_FFFF; corners[5] = 32'h8000_0001;
    if ($urandom_range(3) == 0) return corners[$urandom_range(5)];
    return $urandom;
  endfunction

  initial begin
    vecs[0] = '{32'd5,        32'd7,        1'b0, 32'd12,       1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'h7FFFFFFF, 32'd1,        1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{32'd3,        32'd5,        1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{32'h00000000, 32'h80000000, 1'b1, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{32'hFFFFFFFF, 32'h80000000, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{32'd5,        32'd5,        1'b1, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{32'h80000000, 32'd1,        1'b1, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b1};
    vecs[8] = '{32'hFFFFFFFF, 32'd1,        1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[9] = '{32'h0F0F0F0F, 32'hF0F0F0F1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0};

    rst = 1'b1; a = '0; b = '0; sub = 1'b0; en = 1'b0; clr_sticky = 1'b0;
    mResQ = '0; mPosQ = 1'b0; mNegQ = 1'b0; mPosS = 1'b0; mNegS = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset result_q", result_q, 32'd0);
    checkOutput("reset pos_ovf_sticky", {31'd0, pos_ovf_sticky}, 32'd0);
    checkOutput("reset neg_ovf_sticky", {31'd0, neg_ovf_sticky}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table: checked against both the model and the table itself.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].va, vecs[i].vb, vecs[i].vsub, 1'b0, 1'b0);
      checkOutput("tbl result", result, vecs[i].expRes);
      checkOutput("tbl carry", {31'd0, carry_out}, {31'd0, vecs[i].expCarry});
      checkOutput("tbl pos", {31'd0, pos_overflow}, {31'd0, vecs[i].expPos});
      checkOutput("tbl neg", {31'd0, neg_overflow}, {31'd0, vecs[i].expNeg});
    end

    // Capture an overflow, hold with en=0, clear, then set-wins-over-clear.
    applyStimulus(32'h7FFFFFFF, 32'd1, 1'b0, 1'b1, 1'b0);
    checkOutput("seq pos_ovf_q", {31'd0, pos_ovf_q}, 32'd1);
    checkOutput("seq pos sticky set", {31'd0, pos_ovf_sticky}, 32'd1);
    applyStimulus(32'd5, 32'd7, 1'b0, 1'b0, 1'b0);
    checkOutput("seq hold result_q", result_q, 32'h80000000);
    checkOutput("seq hold sticky", {31'd0, pos_ovf_sticky}, 32'd1);
    applyStimulus(32'd5, 32'd7, 1'b0, 1'b0, 1'b1);
    checkOutput("seq clr sticky", {31'd0, pos_ovf_sticky}, 32'd0);
    applyStimulus(32'h7FFFFFFF, 32'd1, 1'b0, 1'b1, 1'b1);
    checkOutput("seq set wins", {31'd0, pos_ovf_sticky}, 32'd1);
    applyStimulus(32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0);
    checkOutput("seq neg sticky", {31'd0, neg_ovf_sticky}, 32'd1);

    // Asynchronous reset between edges.
    @(negedge clk);
    a = 32'd3; b = 32'd5; sub = 1'b1; en = 1'b1; clr_sticky = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async result_q", result_q, 32'd0);
    checkOutput("async pos_ovf_q", {31'd0, pos_ovf_q}, 32'd0);
    checkOutput("async neg_ovf_q", {31'd0, neg_ovf_q}, 32'd0);
    checkOutput("async pos sticky", {31'd0, pos_ovf_sticky}, 32'd0);
    checkOutput("async neg sticky", {31'd0, neg_ovf_sticky}, 32'd0);
    checkOutput("async comb result", result, 32'hFFFFFFFE);
    #1;
    rst = 1'b0;
    mResQ = '0; mPosQ = 1'b0; mNegQ = 1'b0; mPosS = 1'b0; mNegS = 1'b0;
    en = 1'b0;

    // Random sweep.
    for (int i = 0; i < 10000; i++) begin
      applyStimulus(pickOperand(), pickOperand(), 1'($urandom_range(1)),
                    1'($urandom_range(1)), ($urandom_range(7) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
